// File: rtl/serial_loaded_cpu.sv
`timescale 1ns/1ps
// Serial-loaded 32-bit CPU: UART-style loader fills program memory, then one instruction retires per clock.
// A byte lands in memory on the cycle its stop bit is sampled; rx has no backpressure, bytes outside LOAD are dropped.
module serial_loaded_cpu #(
  parameter int DBIT         = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_W       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        startbut,
  output logic [31:0] check_A,
  output logic [31:0] check_S,
  output logic [20:0] check_PC
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int BIT_W = $clog2(DBIT) + 1;
  localparam int BC_W  = ADDR_W + 3;
  localparam int WORDS = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DBIT - 1);
  localparam logic [BC_W-1:0]  CAP_BYTES = BC_W'(4 * WORDS);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {CPU_LOAD, CPU_RUN, CPU_HALT} cpu_state_t;

  rx_state_t        rx_state, rx_next;
  logic             rx_s1, rx_s2;
  logic [CNT_W-1:0] rx_cnt;
  logic [BIT_W-1:0] rx_bits;
  logic [DBIT-1:0]  rx_shift;
  logic             rx_par;
  logic             half_done, bit_done, cnt_clr, byte_vld;

  cpu_state_t       cpu_state, cpu_next;
  logic [20:0]      pc, pc_next;
  logic [31:0]      regs [8];
  logic [3:0][7:0]  mem [WORDS];
  logic [BC_W-1:0]  byte_cnt;
  logic [ADDR_W:0]  loaded_words;
  logic [31:0]      instr, imm_sx, rs_val, rt_val, rd_val;
  logic [3:0]       op;
  logic [2:0]       rd, rs, rt;
  logic             halt_now, start_go, exec_en, rd_we, mem_we;
  logic             unused_bits;

  // Receiver: state register
  always_ff @(posedge clk) begin
    if (!reset) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  assign half_done = (rx_cnt == HALF_M1);
  assign bit_done  = (rx_cnt == FULL_M1);

  // Receiver: next state
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (!rx_s2) rx_next = RX_START;
      RX_START: if (half_done) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_done && rx_bits == LAST_BIT) rx_next = RX_PAR;
      RX_PAR:   if (bit_done) rx_next = RX_STOP;
      RX_STOP:  if (bit_done) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Receiver: outputs
  always_comb begin
    cnt_clr  = (rx_state == RX_IDLE) || (rx_state == RX_START && half_done) || bit_done;
    byte_vld = (rx_state == RX_STOP) && bit_done && rx_s2 && (rx_par == ^rx_shift);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      rx_par   <= 1'b0;
    end else begin
      rx_s1  <= rx;
      rx_s2  <= rx_s1;
      rx_cnt <= cnt_clr ? '0 : rx_cnt + CNT_W'(1);
      if (rx_state == RX_IDLE) rx_bits <= '0;
      if (rx_state == RX_DATA && bit_done) begin
        rx_shift <= {rx_s2, rx_shift[DBIT-1:1]};
        rx_bits  <= rx_bits + BIT_W'(1);
      end
      if (rx_state == RX_PAR && bit_done) rx_par <= rx_s2;
    end
  end

  assign loaded_words = byte_cnt[ADDR_W+2:2];
  assign instr        = mem[pc[ADDR_W-1:0]];
  assign op           = instr[31:28];
  assign rd           = instr[27:25];
  assign rs           = instr[24:22];
  assign rt           = instr[21:19];
  assign imm_sx       = {{16{instr[15]}}, instr[15:0]};
  assign rs_val       = regs[rs];
  assign rt_val       = regs[rt];
  assign unused_bits  = ^instr[18:16];
  // An out-of-range PC halts before the fetched word is used, so memory aliasing never executes
  assign halt_now     = (pc >= 21'(loaded_words)) || (op == 4'hF);

  // Control: state register
  always_ff @(posedge clk) begin
    if (!reset) cpu_state <= CPU_LOAD;
    else        cpu_state <= cpu_next;
  end

  // Control: next state
  always_comb begin
    cpu_next = cpu_state;
    case (cpu_state)
      CPU_LOAD, CPU_HALT: if (startbut) cpu_next = CPU_RUN;
      CPU_RUN:            if (halt_now) cpu_next = CPU_HALT;
      default:            cpu_next = CPU_LOAD;
    endcase
  end

  // Control: outputs and execute
  always_comb begin
    start_go = 1'b0;
    exec_en  = 1'b0;
    rd_we    = 1'b0;
    rd_val   = '0;
    pc_next  = pc + 21'd1;
    mem_we   = byte_vld && (cpu_state == CPU_LOAD) && (byte_cnt < CAP_BYTES);
    case (cpu_state)
      CPU_LOAD, CPU_HALT: start_go = startbut;
      CPU_RUN: begin
        exec_en = !halt_now;
        case (op)
          4'h1: begin rd_we = 1'b1; rd_val = imm_sx;          end
          4'h2: begin rd_we = 1'b1; rd_val = rs_val + rt_val; end
          4'h3: begin rd_we = 1'b1; rd_val = rs_val - rt_val; end
          4'h4: begin rd_we = 1'b1; rd_val = rs_val & rt_val; end
          4'h5: begin rd_we = 1'b1; rd_val = rs_val | rt_val; end
          4'h6: begin rd_we = 1'b1; rd_val = rs_val ^ rt_val; end
          4'h7: begin rd_we = 1'b1; rd_val = rs_val + imm_sx; end
          4'h8: pc_next = instr[20:0];
          4'h9: if (rs_val == rt_val) pc_next = pc + 21'd1 + imm_sx[20:0];
          4'hA: begin rd_we = 1'b1; rd_val = rs_val;          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc       <= '0;
      byte_cnt <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (mem_we) byte_cnt <= byte_cnt + BC_W'(1);
      if (start_go) begin
        pc <= '0;
        for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else if (exec_en) begin
        pc <= pc_next;
        if (rd_we) regs[rd] <= rd_val;
      end
    end
  end

  // Big-endian packing: the first byte of each group of four lands in bits [31:24]
  always_ff @(posedge clk) begin
    if (mem_we) mem[byte_cnt[ADDR_W+1:2]][2'd3 - byte_cnt[1:0]] <= rx_shift[7:0];
  end

  assign check_A  = regs[0];
  assign check_S  = regs[7];
  assign check_PC = pc;

endmodule

// File: tb/tb_serial_loaded_cpu.sv
`timescale 1ns/1ps
// Bench for serial_loaded_cpu: serial program loads, directed programs and random programs
// checked against an instruction-level interpreter of the loaded byte stream.
module tb_serial_loaded_cpu;
  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset, rx, startbut;
  logic [31:0] check_A, check_S;
  logic [20:0] check_PC;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_loaded_cpu #(.DBIT(8), .CLKS_PER_BIT(CPB), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .rx(rx), .startbut(startbut),
    .check_A(check_A), .check_S(check_S), .check_PC(check_PC)
  );

  // Reference model: accepted byte stream plus architectural state
  bit [7:0]  m_bytes[$];
  bit [7:0]  txq[$];
  bit        m_load;
  bit        m_halt;
  bit [31:0] m_r[8];
  bit [20:0] m_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_clear_arch();
    m_pc = '0;
    m_halt = 1'b0;
    foreach (m_r[i]) m_r[i] = '0;
  endfunction

  function automatic void m_step();
    int nw;
    bit [31:0] w, imm, a, b;
    bit [3:0] op;
    int rd, rs, rt;
    if (m_halt) return;
    nw = m_bytes.size() / 4;
    if (m_pc >= nw) begin m_halt = 1'b1; return; end
    w = {m_bytes[4*m_pc], m_bytes[4*m_pc+1], m_bytes[4*m_pc+2], m_bytes[4*m_pc+3]};
    op = w[31:28];
    rd = int'(w[27:25]);
    rs = int'(w[24:22]);
    rt = int'(w[21:19]);
    imm = 32'($signed(w[15:0]));
    a = m_r[rs];
    b = m_r[rt];
    case (op)
      4'h1: m_r[rd] = imm;
      4'h2: m_r[rd] = a + b;
      4'h3: m_r[rd] = a - b;
      4'h4: m_r[rd] = a & b;
      4'h5: m_r[rd] = a | b;
      4'h6: m_r[rd] = a ^ b;
      4'h7: m_r[rd] = a + imm;
      4'hA: m_r[rd] = a;
      4'hF: begin m_halt = 1'b1; return; end
      default: ;
    endcase
    if (op == 4'h8) m_pc = w[20:0];
    else if (op == 4'h9 && a == b) m_pc = m_pc + 21'd1 + imm[20:0];
    else m_pc = m_pc + 21'd1;
  endfunction

  task automatic do_reset();
    reset = 1'b0; rx = 1'b1; startbut = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    m_bytes.delete();
    m_load = 1'b1;
    m_clear_arch();
  endtask

  task automatic send_byte(input bit [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
    bit [10:0] f;
    f = {~bad_stop, (^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (bad_stop ? 20 : 4) @(negedge clk);
    if (!bad_par && !bad_stop && m_load && m_bytes.size() < 128) m_bytes.push_back(b);
  endtask

  task automatic send_glitch(input int len);
    rx = 1'b0;
    repeat (len) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  function automatic void push_word(input bit [31:0] w);
    txq.push_back(w[31:24]); txq.push_back(w[23:16]);
    txq.push_back(w[15:8]);  txq.push_back(w[7:0]);
  endfunction

  task automatic send_txq(input bit inject);
    while (txq.size() > 0) begin
      if (inject && $urandom_range(0, 7) == 0)
        send_byte(8'($urandom), $urandom_range(0, 1) == 1, 1'b0);
      else if (inject && $urandom_range(0, 15) == 0)
        send_byte(8'($urandom), 1'b0, 1'b1);
      send_byte(txq.pop_front());
    end
  endtask

  // Pulse startbut, let n more edges elapse, compare against the interpreter
  task automatic run_check(input string tag, input int n);
    startbut = 1'b1;
    @(negedge clk);
    startbut = 1'b0;
    if (m_load || m_halt) begin m_load = 1'b0; m_clear_arch(); end
    else m_step();
    repeat (n) begin @(negedge clk); m_step(); end
    chk({tag, "_A"}, check_A, m_r[0]);
    chk({tag, "_S"}, check_S, m_r[7]);
    chk({tag, "_PC"}, 32'(check_PC), 32'(m_pc));
  endtask

  task automatic expect3(input string tag, input bit [31:0] a, input bit [31:0] s, input bit [31:0] p);
    chk({tag, "_Ak"}, check_A, a);
    chk({tag, "_Sk"}, check_S, s);
    chk({tag, "_PCk"}, 32'(check_PC), p);
  endtask

  task automatic queue_p1();
    push_word(32'h1000_0005); push_word(32'h1E00_0007); push_word(32'h2038_0000);
    push_word(32'hF000_0000); push_word(32'h0000_0000);
  endtask

  initial begin
    int nw, n;
    bit [31:0] w;
    reset = 1'b0; rx = 1'b1; startbut = 1'b0;
    repeat (2) @(negedge clk);
    expect3("reset", 0, 0, 0);

    do_reset();
    queue_p1(); send_txq(1'b0);
    run_check("p1", 25);
    expect3("p1", 12, 7, 3);

    do_reset();
    send_byte(8'h10, 1'b1, 1'b0);
    queue_p1(); send_txq(1'b0);
    run_check("badpar", 25);
    expect3("badpar", 12, 7, 3);

    do_reset();
    send_byte(8'h10, 1'b0, 1'b1);
    send_glitch(3);
    queue_p1(); send_txq(1'b0);
    run_check("badstop", 25);
    expect3("badstop", 12, 7, 3);

    do_reset();
    push_word(32'h1000_0001); push_word(32'h9000_0001); push_word(32'h1000_0009);
    push_word(32'hE000_0000); push_word(32'hF000_0000);
    send_txq(1'b0);
    run_check("beq", 10);
    expect3("beq", 1, 0, 4);

    do_reset();
    push_word(32'h1000_0005); txq.push_back(8'h10); txq.push_back(8'h00);
    send_txq(1'b0);
    run_check("partial", 6);
    expect3("partial", 5, 0, 1);
    send_byte(8'h00); send_byte(8'h07);
    run_check("halt_rx", 6);
    expect3("halt_rx", 5, 0, 1);

    do_reset();
    push_word(32'h7000_0001); push_word(32'h8000_0000);
    send_txq(1'b0);
    run_check("loop", 9);
    expect3("loop", 5, 0, 1);
    run_check("run_start", 5);
    expect3("run_start", 8, 0, 1);
    reset = 1'b0;
    @(negedge clk);
    expect3("midrst", 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    m_bytes.delete(); m_load = 1'b1; m_clear_arch();
    run_check("noload", 3);
    expect3("noload", 0, 0, 0);

    for (int t = 0; t < 6; t++) begin
      do_reset();
      nw = $urandom_range(2, 6);
      for (int k = 0; k < nw; k++) begin
        w = $urandom;
        if (w[31:28] == 4'hF && $urandom_range(0, 3) != 0) w[31:28] = 4'h1;
        if (w[31:28] == 4'h8) w[20:0] = 21'($urandom_range(0, nw));
        if (w[31:28] == 4'h9) w[15:0] = 16'($urandom_range(0, 6) - 3);
        push_word(w);
      end
      for (int k = 0; k < $urandom_range(0, 3); k++) txq.push_back(8'($urandom));
      send_txq(1'b1);
      n = $urandom_range(1, 30);
      run_check($sformatf("rnd%0d", t), n);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
